adder_approx_accum: RTL and testbench

//  Multi-channel approximate accumulator; parametrised successor to the fixed-truncation adder.

---
 rtl/adder_approx_pkg.sv | 24 ++
 rtl/approx_add_unit.sv | 67 ++++++
 rtl/adder_approx_accum.sv | 171 +++++++++++++++++
 tb/tb_adder_approx_accum.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adder_approx_pkg.sv
// Shared types for the approximate accumulator and the array-level config decoder.
package adder_approx_pkg;

  // Arithmetic mode selected per batch; AM_RSVD behaves exactly like AM_EXACT.
  typedef enum logic [1:0] {
    AM_EXACT = 2'd0,
    AM_TRUNC = 2'd1,
    AM_LOA   = 2'd2,
    AM_RSVD  = 2'd3
  } approx_mode_e;

  // Batch controller states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_HOLD  = 2'd2
  } acc_state_e;

  // True for modes in which the approximation level actually changes the result.
  function automatic logic mode_uses_level(approx_mode_e mode);
    return (mode == AM_TRUNC) || (mode == AM_LOA);
  endfunction

endpackage

// File: rtl/approx_add_unit.sv
// Combinational per-channel adder: exact, low-part truncation, or lower-part OR (LOA).
// With ADDER_ACC_SAT_EN defined the high-part sum saturates and an overflow flag is produced.
module approx_add_unit
  import adder_approx_pkg::*;
#(
  parameter int OC_W  = 24,
  parameter int LVL_W = 4
) (
  input  logic [OC_W-1:0]  a,
  input  logic [OC_W-1:0]  b,
  input  approx_mode_e     mode,
  input  logic [LVL_W-1:0] lvl,
  output logic [OC_W-1:0]  sum
`ifdef ADDER_ACC_SAT_EN
  ,
  output logic             ovf
`endif
);

  logic [LVL_W-1:0] eff_lvl;
  logic [OC_W-1:0]  low_mask;
  logic [OC_W-1:0]  top_low_bit;
  logic [OC_W-1:0]  a_hi;
  logic [OC_W-1:0]  b_hi;
  logic [OC_W-1:0]  carry_in;
  logic [OC_W-1:0]  low_part;

  // Split both operands at the approximation level; the high parts always add exactly,
  // while the low part is dropped (truncate) or OR-ed with a carry guess into the high part (LOA).
  always_comb begin
    eff_lvl     = mode_uses_level(mode) ? lvl : '0;
    low_mask    = (OC_W'(1) << eff_lvl) - OC_W'(1);
    top_low_bit = low_mask ^ (low_mask >> 1);
    a_hi        = a & ~low_mask;
    b_hi        = b & ~low_mask;
    low_part    = '0;
    carry_in    = '0;
    if (mode == AM_LOA) begin
      low_part = (a | b) & low_mask;
      carry_in = (a & b & top_low_bit) << 1;
    end
  end

`ifdef ADDER_ACC_SAT_EN
  logic [OC_W:0] hi_sum;

  // One extra bit catches signed overflow of the high-part sum and clamps to the rails.
  always_comb begin
    hi_sum = {a_hi[OC_W-1], a_hi} + {b_hi[OC_W-1], b_hi} + {1'b0, carry_in};
    ovf    = hi_sum[OC_W] ^ hi_sum[OC_W-1];
    if (ovf) begin
      sum = hi_sum[OC_W] ? {1'b1, {(OC_W-1){1'b0}}} : {1'b0, {(OC_W-1){1'b1}}};
    end else begin
      sum = hi_sum[OC_W-1:0] | low_part;
    end
  end
`else
  logic [OC_W-1:0] hi_sum;

  // Plain two's-complement wrap; the high sum has zero low bits so OR merges the low part.
  always_comb begin
    hi_sum = a_hi + b_hi + carry_in;
    sum    = hi_sum | low_part;
  end
`endif

endmodule

// File: rtl/adder_approx_accum.sv
// Multi-channel approximate accumulator with valid/ready on both sides.
// Optional feature macro: ADDER_ACC_SAT_EN (saturating sums and sticky per-channel o_sat).
module adder_approx_accum
  import adder_approx_pkg::*;
#(
  parameter int N_CH       = 4,
  parameter int IP_W       = 16,
  parameter int OC_W       = 24,
  parameter int MAX_APPROX = 8,
  parameter int CNT_W      = 8
) (
  input  logic                              i_clk,
  input  logic                              i_rstn,
  input  logic                              i_valid,
  output logic                              o_ready,
  input  logic [N_CH*IP_W-1:0]              i_p,
  input  logic [CNT_W-1:0]                  i_len,
  input  logic [1:0]                        i_mode,
  input  logic [$clog2(MAX_APPROX+1)-1:0]   i_approx_lvl,
  output logic                              o_valid,
  input  logic                              i_ready,
  output logic [N_CH*OC_W-1:0]              o_c,
  output logic [N_CH-1:0]                   o_sat
);

  localparam int               LVL_W   = $clog2(MAX_APPROX + 1);
  localparam logic [LVL_W-1:0] MAX_LVL = LVL_W'(MAX_APPROX);

  acc_state_e       state;
  acc_state_e       next_state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] len_reg;
  approx_mode_e     mode_reg;
  logic [LVL_W-1:0] lvl_reg;
  logic             first_beat;
  logic             beat_ok;
  approx_mode_e     cur_mode;
  logic [LVL_W-1:0] cur_lvl;
  logic [LVL_W-1:0] in_lvl_clamped;

  assign beat_ok        = i_valid & o_ready;
  assign in_lvl_clamped = (i_approx_lvl > MAX_LVL) ? MAX_LVL : i_approx_lvl;
  assign cur_mode       = first_beat ? approx_mode_e'(i_mode) : mode_reg;
  assign cur_lvl        = first_beat ? in_lvl_clamped : lvl_reg;

  // Batch controller state register; reset abandons any batch in flight.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state and handshake decode; a length of 0 or 1 finishes on the first beat.
  always_comb begin
    next_state = state;
    o_ready    = 1'b0;
    o_valid    = 1'b0;
    first_beat = 1'b0;
    case (state)
      ST_IDLE: begin
        o_ready = 1'b1;
        if (i_valid) begin
          first_beat = 1'b1;
          next_state = (i_len <= CNT_W'(1)) ? ST_HOLD : ST_ACCUM;
        end
      end
      ST_ACCUM: begin
        o_ready = 1'b1;
        if (i_valid && (cnt + CNT_W'(1) == len_reg)) begin
          next_state = ST_HOLD;
        end
      end
      ST_HOLD: begin
        o_valid = 1'b1;
        if (i_ready) begin
          next_state = ST_IDLE;
        end
      end
      default: begin
        next_state = ST_IDLE;
      end
    endcase
  end

  // Configuration is captured only with the first beat so mid-batch changes are ignored.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      len_reg  <= '0;
      mode_reg <= AM_EXACT;
      lvl_reg  <= '0;
    end else if (beat_ok && first_beat) begin
      len_reg  <= i_len;
      mode_reg <= approx_mode_e'(i_mode);
      lvl_reg  <= in_lvl_clamped;
    end
  end

  // Beat counter: restarts at 1 on the first beat, advances on every accepted beat.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      cnt <= '0;
    end else if (beat_ok) begin
      cnt <= first_beat ? CNT_W'(1) : cnt + CNT_W'(1);
    end
  end

  for (genvar k = 0; k < N_CH; k++) begin : g_ch
    logic [OC_W-1:0] a_in;
    logic [OC_W-1:0] b_in;
    logic [OC_W-1:0] sum;
    logic [OC_W-1:0] acc_q;

    assign a_in = first_beat ? '0 : acc_q;
    assign b_in = OC_W'($signed(i_p[k*IP_W +: IP_W]));

`ifdef ADDER_ACC_SAT_EN
    logic ovf;
    logic sat_q;

    approx_add_unit #(
      .OC_W  (OC_W),
      .LVL_W (LVL_W)
    ) u_add (
      .a    (a_in),
      .b    (b_in),
      .mode (cur_mode),
      .lvl  (cur_lvl),
      .sum  (sum),
      .ovf  (ovf)
    );

    // Sticky saturation flag, restarted by the first beat of each batch.
    always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
        sat_q <= 1'b0;
      end else if (beat_ok) begin
        sat_q <= first_beat ? ovf : (sat_q | ovf);
      end
    end

    assign o_sat[k] = sat_q;
`else
    approx_add_unit #(
      .OC_W  (OC_W),
      .LVL_W (LVL_W)
    ) u_add (
      .a    (a_in),
      .b    (b_in),
      .mode (cur_mode),
      .lvl  (cur_lvl),
      .sum  (sum)
    );

    assign o_sat[k] = 1'b0;
`endif

    // Accumulator register; it only moves on accepted beats so o_c is stable while held.
    always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
        acc_q <= '0;
      end else if (beat_ok) begin
        acc_q <= sum;
      end
    end

    assign o_c[k*OC_W +: OC_W] = acc_q;
  end

endmodule

// File: tb/tb_adder_approx_accum.sv
// Scoreboard bench for adder_approx_accum: randomized batches checked against an arithmetic model.
module tb_adder_approx_accum;

  localparam int N_CH       = 4;
  localparam int IP_W       = 16;
  localparam int OC_W       = 20;
  localparam int MAX_APPROX = 8;
  localparam int CNT_W      = 8;
  localparam int LVL_W      = $clog2(MAX_APPROX + 1);

  typedef struct packed {
    logic [N_CH*OC_W-1:0] c;
    logic [N_CH-1:0]      sat;
  } exp_t;

  logic                    i_clk = 1'b0;
  logic                    i_rstn;
  logic                    i_valid;
  logic                    o_ready;
  logic [N_CH*IP_W-1:0]    i_p;
  logic [CNT_W-1:0]        i_len;
  logic [1:0]              i_mode;
  logic [LVL_W-1:0]        i_approx_lvl;
  logic                    o_valid;
  logic                    i_ready;
  logic [N_CH*OC_W-1:0]    o_c;
  logic [N_CH-1:0]         o_sat;

  int                      n_checks = 0;
  int                      n_errors = 0;
  int                      ready_pct = 100;
  exp_t                    exp_q[$];
  logic [N_CH*IP_W-1:0]    beat_q[$];

  adder_approx_accum #(
    .N_CH       (N_CH),
    .IP_W       (IP_W),
    .OC_W       (OC_W),
    .MAX_APPROX (MAX_APPROX),
    .CNT_W      (CNT_W)
  ) dut (
    .i_clk        (i_clk),
    .i_rstn       (i_rstn),
    .i_valid      (i_valid),
    .o_ready      (o_ready),
    .i_p          (i_p),
    .i_len        (i_len),
    .i_mode       (i_mode),
    .i_approx_lvl (i_approx_lvl),
    .o_valid      (o_valid),
    .i_ready      (i_ready),
    .o_c          (o_c),
    .o_sat        (o_sat)
  );

  always #5 i_clk = ~i_clk;

  task automatic checkOutput(string name, logic [63:0] actual, logic [63:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Reference arithmetic on signed integers: split each operand into a multiple of 2^L
  // and a non-negative remainder, then combine according to the mode.
  function automatic logic [OC_W-1:0] modelAdd(logic [OC_W-1:0] a, logic [OC_W-1:0] b,
                                               int mode, int lvl, output bit sat);
    longint va, vb, p, a_lo, b_lo, a_hi, b_hi, s, lo, lim_hi, lim_lo;
    int     l;
    va = longint'($signed(a));
    vb = longint'($signed(b));
    l  = (mode == 1 || mode == 2) ? ((lvl > MAX_APPROX) ? MAX_APPROX : lvl) : 0;
    p  = longint'(1) << l;
    a_lo = ((va % p) + p) % p;
    b_lo = ((vb % p) + p) % p;
    a_hi = va - a_lo;
    b_hi = vb - b_lo;
    lo   = 0;
    if (mode == 1) begin
      s = a_hi + b_hi;
    end else if (mode == 2) begin
      s  = a_hi + b_hi;
      if (l > 0 && a_lo >= p / 2 && b_lo >= p / 2) s = s + p;
      lo = a_lo | b_lo;
    end else begin
      s = va + vb;
    end
    lim_hi = (longint'(1) << (OC_W - 1)) - 1;
    lim_lo = -(longint'(1) << (OC_W - 1));
    sat = 1'b0;
`ifdef ADDER_ACC_SAT_EN
    if (s > lim_hi) begin
      sat = 1'b1;
      return OC_W'(lim_hi);
    end
    if (s < lim_lo) begin
      sat = 1'b1;
      return OC_W'(lim_lo);
    end
`else
    if (lim_hi < lim_lo) sat = 1'b1;
`endif
    return OC_W'(s + lo);
  endfunction

  // Hold i_valid until a beat is taken; reports whether it was accepted within the budget.
  task automatic sendBeat(output bit ok);
    bit rdy;
    int waited;
    ok     = 1'b0;
    waited = 0;
    forever begin
      @(negedge i_clk);
      rdy = o_ready;
      @(posedge i_clk);
      #1;
      if (rdy) begin
        ok = 1'b1;
        return;
      end
      waited++;
      if (waited > 300) return;
    end
  endtask

  // Drive one batch (beats from beat_q first, then random) and push its expected result.
  task automatic applyStimulus(int len, int mode, int lvl);
    logic [OC_W-1:0]      acc[N_CH];
    logic [N_CH-1:0]      sat_acc;
    logic [N_CH*IP_W-1:0] p;
    logic [OC_W-1:0]      b;
    exp_t                 e;
    bit                   s, ok;
    int                   nbeats;
    nbeats  = (len == 0) ? 1 : len;
    sat_acc = '0;
    for (int k = 0; k < N_CH; k++) acc[k] = '0;
    for (int i = 0; i < nbeats; i++) begin
      if (beat_q.size() > 0) p = beat_q.pop_front();
      else for (int k = 0; k < N_CH; k++) p[k*IP_W +: IP_W] = IP_W'($urandom);
      for (int k = 0; k < N_CH; k++) begin
        b      = OC_W'(longint'($signed(p[k*IP_W +: IP_W])));
        acc[k] = modelAdd(acc[k], b, mode, lvl, s);
        if (s) sat_acc[k] = 1'b1;
      end
      i_valid = 1'b1;
      i_p     = p;
      if (i == 0) begin
        i_len        = CNT_W'(len);
        i_mode       = 2'(mode);
        i_approx_lvl = LVL_W'(lvl);
      end else begin
        i_len        = CNT_W'($urandom);
        i_mode       = 2'($urandom);
        i_approx_lvl = LVL_W'($urandom);
      end
      sendBeat(ok);
      if (!ok) begin
        checkOutput("beat_accept_timeout", 64'd0, 64'd1);
        i_valid = 1'b0;
        return;
      end
      if (i == nbeats - 1) begin
        for (int k = 0; k < N_CH; k++) e.c[k*OC_W +: OC_W] = acc[k];
        e.sat = sat_acc;
        exp_q.push_back(e);
        checkOutput("latency_valid", 64'(o_valid), 64'd1);
        i_valid = 1'b0;
      end else if ($urandom_range(3) == 0) begin
        i_valid = 1'b0;
        repeat ($urandom_range(2) + 1) @(posedge i_clk);
        #1;
      end
    end
  endtask

  task automatic waitDrain();
    int waited;
    waited = 0;
    while (exp_q.size() > 0 && waited < 2000) begin
      @(posedge i_clk);
      waited++;
    end
    #1;
    if (exp_q.size() > 0) begin
      n_checks++;
      n_errors++;
      $display("[TB] FAIL drain_timeout: got %0d pending results, expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  // Downstream ready generator, changed just after each rising edge.
  initial begin
    i_ready = 1'b0;
    forever begin
      @(posedge i_clk);
      #1;
      i_ready = ($urandom_range(99) < ready_pct);
    end
  end

  // Monitor: compares each accepted result, checks stability under stall and the bubble after.
  initial begin
    bit                   stalled, handshook;
    logic [N_CH*OC_W-1:0] held_c;
    exp_t                 e;
    stalled   = 1'b0;
    handshook = 1'b0;
    forever begin
      @(negedge i_clk);
      if (i_rstn !== 1'b1) begin
        stalled   = 1'b0;
        handshook = 1'b0;
        continue;
      end
      if (handshook) begin
        checkOutput("bubble_valid", 64'(o_valid), 64'd0);
        checkOutput("bubble_ready", 64'(o_ready), 64'd1);
      end
      if (stalled) begin
        checkOutput("stall_valid", 64'(o_valid), 64'd1);
        checkOutput("stall_data", 64'(o_c), 64'(held_c));
      end
      handshook = 1'b0;
      stalled   = 1'b0;
      if (o_valid === 1'b1) begin
        checkOutput("hold_ready", 64'(o_ready), 64'd0);
        if (i_ready) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("[TB] FAIL unexpected_result: got 0x%0h, expected no result", o_c);
          end else begin
            e = exp_q.pop_front();
            for (int k = 0; k < N_CH; k++)
              checkOutput($sformatf("ch%0d_result", k), 64'(o_c[k*OC_W +: OC_W]),
                          64'(e.c[k*OC_W +: OC_W]));
            checkOutput("sat_flags", 64'(o_sat), 64'(e.sat));
          end
          handshook = 1'b1;
        end else begin
          stalled = 1'b1;
          held_c  = o_c;
        end
      end
    end
  end

  initial begin
    logic [N_CH*IP_W-1:0] p;
    bit                   ok;
    i_rstn       = 1'b0;
    i_valid      = 1'b0;
    i_p          = '0;
    i_len        = '0;
    i_mode       = '0;
    i_approx_lvl = '0;
    #2;
    checkOutput("reset_valid", 64'(o_valid), 64'd0);
    checkOutput("reset_ready", 64'(o_ready), 64'd1);
    checkOutput("reset_c", 64'(o_c), 64'd0);
    checkOutput("reset_sat", 64'(o_sat), 64'd0);
    #20;
    i_rstn = 1'b1;
    @(posedge i_clk);
    #1;

    $display("[TB] exact batch 100,-30,7");
    foreach (beat_q[j]) beat_q.delete(j);
    p = '0; p[15:0] = 16'd100;  beat_q.push_back(p);
    p = '0; p[15:0] = -16'sd30; beat_q.push_back(p);
    p = '0; p[15:0] = 16'd7;    beat_q.push_back(p);
    applyStimulus(3, 0, 0);

    $display("[TB] truncate and LOA batches");
    p = '0; p[15:0] = 16'h001F; beat_q.push_back(p);
    p = '0; p[15:0] = 16'h0011; beat_q.push_back(p);
    applyStimulus(2, 1, 4);
    p = '0; p[15:0] = 16'h000B; beat_q.push_back(p);
    p = '0; p[15:0] = 16'h0006; beat_q.push_back(p);
    applyStimulus(2, 2, 4);
    waitDrain();

    $display("[TB] backpressure in HOLD");
    ready_pct = 0;
    applyStimulus(2, 2, 3);
    repeat (5) @(posedge i_clk);
    ready_pct = 100;
    waitDrain();

    $display("[TB] overflow batches");
    for (int i = 0; i < 34; i++) beat_q.push_back({N_CH{16'h7FFF}});
    applyStimulus(34, 0, 0);
    for (int i = 0; i < 34; i++) beat_q.push_back({N_CH{16'h8000}});
    applyStimulus(34, 2, 6);
    waitDrain();

    $display("[TB] reset during accumulation");
    i_valid = 1'b1; i_len = 8'd5; i_mode = 2'd0; i_approx_lvl = '0;
    i_p = {N_CH{16'h0123}};
    sendBeat(ok);
    sendBeat(ok);
    i_valid = 1'b0;
    #2;
    i_rstn = 1'b0;
    #1;
    checkOutput("midreset_valid", 64'(o_valid), 64'd0);
    checkOutput("midreset_ready", 64'(o_ready), 64'd1);
    checkOutput("midreset_c", 64'(o_c), 64'd0);
    #10;
    i_rstn = 1'b1;
    @(posedge i_clk);
    #1;
    checkOutput("postreset_valid", 64'(o_valid), 64'd0);
    checkOutput("postreset_ready", 64'(o_ready), 64'd1);
    beat_q.push_back({16'd3, 16'd2, 16'd1, 16'd5});
    applyStimulus(1, 0, 0);
    waitDrain();

    $display("[TB] randomized batches");
    for (int t = 0; t < 60; t++) begin
      ready_pct = $urandom_range(100, 30);
      applyStimulus($urandom_range(10), $urandom_range(3), $urandom_range(15));
    end
    ready_pct = 100;
    waitDrain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
